apb_cmd_master: RTL and testbench



---
 rtl/apb_master_pkg.sv | 22 ++
 rtl/apb_watchdog.sv | 51 +++++
 rtl/apb_cmd_master.sv | 162 ++++++++++++++++
 tb/tb_apb_cmd_master.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_master_pkg.sv
// Shared types and helpers for the APB command master and its watchdog.
package apb_master_pkg;

    // Transfer sequencing states of the APB initiator.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    // APB phase encodings as {PSEL, PENABLE}.
    localparam logic [1:0] PHASE_IDLE   = 2'b00;
    localparam logic [1:0] PHASE_SETUP  = 2'b10;
    localparam logic [1:0] PHASE_ACCESS = 2'b11;

    // Watchdog counter width: enough bits to hold TIMEOUT_CYCLES, at least 1.
    function automatic int wd_cnt_width(input int timeout_cycles);
        return (timeout_cycles < 1) ? 1 : $clog2(timeout_cycles + 1);
    endfunction

endpackage : apb_master_pkg

// File: rtl/apb_watchdog.sv
// Saturating loadable up/down counter with clear and an expire flag.
// expire_o is high while the count sits at LIMIT-1; LIMIT=0 never expires.
module apb_watchdog
    import apb_master_pkg::*;
#(
    parameter int LIMIT = 255,
    parameter int WIDTH = wd_cnt_width(LIMIT)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    input  logic             down_i,
    output logic             expire_o
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] LAST    = WIDTH'((LIMIT == 0) ? 0 : LIMIT - 1);

    logic [WIDTH-1:0] count_q, count_d;

    // Next count: clear beats load beats count; both directions saturate.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (en_i) begin
            if (down_i) begin
                if (count_q != '0) count_d = count_q - CNT_ONE;
            end else begin
                if (count_q != CNT_MAX) count_d = count_q + CNT_ONE;
            end
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_ni) count_q <= '0;
        else         count_q <= count_d;
    end

    assign expire_o = (LIMIT != 0) && (count_q == LAST);

endmodule : apb_watchdog

// File: rtl/apb_cmd_master.sv
// APB3 initiator: turns a valid/ready command stream into single APB3
// transfers and returns read data / error status on a response stream.
// A PREADY watchdog keeps a hung slave from stalling the requester.
module apb_cmd_master
    import apb_master_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  PCLK,
    input  logic                  PRESETN,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam int WD_W = wd_cnt_width(TIMEOUT_CYCLES);

    apb_state_e            state_q, state_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;

    logic wd_clear;
    logic wd_en;
    logic wd_expire;

    apb_watchdog #(
        .LIMIT (TIMEOUT_CYCLES),
        .WIDTH (WD_W)
    ) u_watchdog (
        .clk_i      (PCLK),
        .rst_ni     (PRESETN),
        .clear_i    (wd_clear),
        .load_i     (1'b0),
        .load_val_i ('0),
        .en_i       (wd_en),
        .down_i     (1'b0),
        .expire_o   (wd_expire)
    );

    // Next-state and registered-output decode for the transfer sequencer.
    always_comb begin
        state_d       = state_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        wd_clear      = 1'b0;
        wd_en         = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    pwrite_d            = cmd_write;
                    paddr_d             = cmd_addr;
                    pwdata_d            = cmd_wdata;
                    {psel_d, penable_d} = PHASE_SETUP;
                    state_d             = SETUP;
                end
            end
            SETUP: begin
                {psel_d, penable_d} = PHASE_ACCESS;
                wd_clear            = 1'b1;
                state_d             = ACCESS;
            end
            ACCESS: begin
                // A slave completing on the expiry cycle wins over the watchdog.
                if (PREADY) begin
                    rsp_rdata_d         = pwrite_q ? '0 : PRDATA;
                    rsp_err_d           = PSLVERR;
                    rsp_timeout_d       = 1'b0;
                    {psel_d, penable_d} = PHASE_IDLE;
                    rsp_valid_d         = 1'b1;
                    state_d             = RESP;
                end else if (wd_expire) begin
                    rsp_rdata_d         = '0;
                    rsp_err_d           = 1'b1;
                    rsp_timeout_d       = 1'b1;
                    {psel_d, penable_d} = PHASE_IDLE;
                    rsp_valid_d         = 1'b1;
                    state_d             = RESP;
                end else begin
                    wd_en = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset drops the bus and discards any response.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule : apb_cmd_master

// File: tb/tb_apb_cmd_master.sv
// Directed self-checking bench for apb_cmd_master with a response scoreboard.
// Inputs are driven and outputs sampled on the falling edge of PCLK.
module tb_apb_cmd_master;

    localparam int TO = 4;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        timeout;
    } rsp_t;

    logic        PCLK;
    logic        PRESETN;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int   checks   = 0;
    int   failures = 0;
    rsp_t sb_q[$];

    apb_cmd_master #(
        .ADDR_WIDTH     (8),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .PCLK        (PCLK),
        .PRESETN     (PRESETN),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One complete transfer, starting and ending on a falling edge in IDLE.
    // delay: ACCESS cycles with PREADY low before PREADY rises (>= TO never rises in time).
    // hold:  cycles rsp_ready stays low, with cmd_valid asserted, once rsp_valid is up.
    task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                        input int delay, input logic [31:0] rd, input logic serr, input int hold);
        rsp_t e;
        rsp_t got;
        int   acc;
        int   exp_acc;

        chk_b("idle_cmd_ready", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        if (delay >= TO) begin
            e.rdata = 32'h0; e.err = 1'b1; e.timeout = 1'b1;
            exp_acc = TO;
        end else begin
            e.rdata = wr ? 32'h0 : rd; e.err = serr; e.timeout = 1'b0;
            exp_acc = delay + 1;
        end
        sb_q.push_back(e);

        @(negedge PCLK);  // SETUP
        cmd_valid = 1'b0;
        cmd_addr  = ~addr;
        cmd_wdata = ~wd;
        chk_b("setup_psel", PSEL, 1'b1);
        chk_b("setup_penable", PENABLE, 1'b0);
        chk_b("setup_cmd_ready", cmd_ready, 1'b0);
        chk_b("setup_pwrite", PWRITE, wr);
        chk_w("setup_paddr", 32'(PADDR), 32'(addr));
        chk_w("setup_pwdata", PWDATA, wd);

        acc = 0;
        @(negedge PCLK);  // first ACCESS cycle
        while (PSEL === 1'b1 && PENABLE === 1'b1 && acc < 20) begin
            chk_w("access_paddr", 32'(PADDR), 32'(addr));
            chk_w("access_pwdata", PWDATA, wd);
            chk_b("access_cmd_ready", cmd_ready, 1'b0);
            if (acc == delay) begin
                PREADY = 1'b1; PRDATA = rd; PSLVERR = serr;
            end else begin
                // Junk on the sampled-only-with-PREADY inputs must be ignored.
                PREADY = 1'b0; PRDATA = 32'hBAD0_0000 | 32'(acc); PSLVERR = 1'b1;
            end
            acc++;
            @(negedge PCLK);
        end
        PREADY = 1'b0; PRDATA = 32'h0; PSLVERR = 1'b0;
        chk_w("access_cycles", 32'(acc), 32'(exp_acc));
        chk_b("resp_valid", rsp_valid, 1'b1);
        chk_b("resp_psel", PSEL, 1'b0);
        chk_b("resp_penable", PENABLE, 1'b0);
        chk_w("resp_paddr_hold", 32'(PADDR), 32'(addr));

        for (int i = 0; i < hold; i++) begin
            rsp_ready = 1'b0;
            cmd_valid = 1'b1;
            chk_b("stall_cmd_ready", cmd_ready, 1'b0);
            chk_b("stall_rsp_valid", rsp_valid, 1'b1);
            chk_w("stall_rdata", rsp_rdata, e.rdata);
            chk_b("stall_err", rsp_err, e.err);
            @(negedge PCLK);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        if (sb_q.size() == 0) begin
            chk_w("sb_nonempty", 32'(sb_q.size()), 32'd1);
        end else begin
            got = sb_q.pop_front();
            chk_w("rsp_rdata", rsp_rdata, got.rdata);
            chk_b("rsp_err", rsp_err, got.err);
            chk_b("rsp_timeout", rsp_timeout, got.timeout);
        end
        @(negedge PCLK);  // back in IDLE
        rsp_ready = 1'b0;
        chk_b("post_rsp_valid", rsp_valid, 1'b0);
        chk_b("post_cmd_ready", cmd_ready, 1'b1);
    endtask

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        PRESETN   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 8'h0;
        cmd_wdata = 32'h0;
        rsp_ready = 1'b0;
        PRDATA    = 32'h0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;

        // Reset values
        @(negedge PCLK);
        @(negedge PCLK);
        chk_b("rst_psel", PSEL, 1'b0);
        chk_b("rst_penable", PENABLE, 1'b0);
        chk_b("rst_pwrite", PWRITE, 1'b0);
        chk_w("rst_paddr", 32'(PADDR), 32'h0);
        chk_w("rst_pwdata", PWDATA, 32'h0);
        chk_b("rst_rsp_valid", rsp_valid, 1'b0);
        chk_w("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk_b("rst_rsp_err", rsp_err, 1'b0);
        chk_b("rst_rsp_timeout", rsp_timeout, 1'b0);
        chk_b("rst_cmd_ready", cmd_ready, 1'b1);
        PRESETN = 1'b1;
        @(negedge PCLK);

        // Write, immediate PREADY
        xfer(1'b1, 8'hA0, 32'h0000_0005, 0, 32'h0, 1'b0, 0);
        // Read, PREADY after 3 wait cycles (4th ACCESS cycle, also the expiry cycle)
        xfer(1'b0, 8'h90, 32'h0, 3, 32'h0000_000A, 1'b0, 0);
        // Read with slave error
        xfer(1'b0, 8'h44, 32'h0, 1, 32'hDEAD_BEEF, 1'b1, 0);
        // Read, slave never ready: watchdog fires
        xfer(1'b0, 8'h10, 32'h0, 99, 32'h1234_5678, 1'b0, 0);
        // Write, slave never ready: watchdog fires
        xfer(1'b1, 8'h11, 32'hCAFE_F00D, 99, 32'h0, 1'b0, 0);
        // Write with slave error: rdata stays 0
        xfer(1'b1, 8'h22, 32'h0000_00FF, 2, 32'h7777_7777, 1'b1, 0);
        // Response back-pressure with a pending command
        xfer(1'b1, 8'h20, 32'h0000_1234, 0, 32'h0, 1'b0, 5);
        // Next command accepted in the first IDLE cycle
        xfer(1'b0, 8'h30, 32'h0, 0, 32'h0000_0003, 1'b0, 0);

        // Reset during ACCESS
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h55; cmd_wdata = 32'h0;
        @(negedge PCLK);  // SETUP
        cmd_valid = 1'b0;
        @(negedge PCLK);  // ACCESS
        chk_b("pre_rst_penable", PENABLE, 1'b1);
        @(negedge PCLK);  // ACCESS, waiting
        #2 PRESETN = 1'b0;
        #1;
        chk_b("async_rst_psel", PSEL, 1'b0);
        chk_b("async_rst_penable", PENABLE, 1'b0);
        chk_b("async_rst_rsp_valid", rsp_valid, 1'b0);
        @(negedge PCLK);
        PRESETN = 1'b1;
        @(negedge PCLK);
        chk_b("after_rst_cmd_ready", cmd_ready, 1'b1);
        chk_b("after_rst_psel", PSEL, 1'b0);
        chk_b("after_rst_rsp_valid", rsp_valid, 1'b0);

        // Normal operation after reset
        xfer(1'b0, 8'h66, 32'h0, 1, 32'h0000_00C3, 1'b0, 0);

        chk_w("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_apb_cmd_master
